// File: rtl/ssd_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed, active-low 4-digit seven-segment bus.
// Optional macro SSD_HEX_DECODE_EN also accepts the A..F glyphs as valid digits.
module ssd_scan_decoder #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ssd_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] bcd_out,
    output logic [3:0]  valid_out,
    output logic [3:0]  err_out,
    output logic [3:0]  dp_out,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        bus_err
);

    localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYC);
    localparam logic [23:0] TMO_LIM    = 24'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ssd_s1_q, ssd_s1_d, ssd_s2_q, ssd_s2_d, ssd_prev_q, ssd_prev_d;
    logic [3:0]  dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_prev_q, dig_prev_d;

    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  dp_q, dp_d;
    logic        upd_q, upd_d;
    logic [1:0]  upd_idx_q, upd_idx_d;
    logic        bus_err_q, bus_err_d;
    logic [23:0] tmo_q [4];
    logic [23:0] tmo_d [4];

    logic        sample_changed;
    logic        run_done;
    logic        single_dig;
    logic [1:0]  commit_idx;
    logic        do_commit;
    logic        do_bus_err;
    logic [3:0]  dec_val;
    logic        dec_hit;
    logic        dec_blank;

    always_comb begin
        ssd_s1_d   = ssd_in;
        ssd_s2_d   = ssd_s1_q;
        ssd_prev_d = ssd_s2_q;
        dig_s1_d   = dig_in;
        dig_s2_d   = dig_s1_q;
        dig_prev_d = dig_s2_q;
    end

    // Sync registers reset to the idle bus so no spurious run is seen after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ssd_s1_q   <= 8'hFF;
            ssd_s2_q   <= 8'hFF;
            ssd_prev_q <= 8'hFF;
            dig_s1_q   <= 4'hF;
            dig_s2_q   <= 4'hF;
            dig_prev_q <= 4'hF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ssd_s1_q   <= ssd_s1_d;
            ssd_s2_q   <= ssd_s2_d;
            ssd_prev_q <= ssd_prev_d;
            dig_s1_q   <= dig_s1_d;
            dig_s2_q   <= dig_s2_d;
            dig_prev_q <= dig_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_changed) begin
            if (dig_s2_q == 4'hF) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = COUNT;
                cnt_d   = 8'd1;
            end
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                COUNT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (run_done) state_d = HELD;
                end
                HELD: state_d = HELD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sample_changed = (ssd_s2_q != ssd_prev_q) || (dig_s2_q != dig_prev_q);
        run_done       = (state_q == COUNT) && !sample_changed && ((cnt_q + 8'd1) == STABLE_LIM);
        single_dig     = 1'b1;
        commit_idx     = 2'd0;
        case (dig_s2_q)
            4'b1110: commit_idx = 2'd0;
            4'b1101: commit_idx = 2'd1;
            4'b1011: commit_idx = 2'd2;
            4'b0111: commit_idx = 2'd3;
            default: single_dig = 1'b0;
        endcase
        do_commit  = run_done && single_dig;
        do_bus_err = run_done && !single_dig;
    end

    // Patterns are written as full bytes with dp off; the dp line never affects matching.
    always_comb begin
        dec_val   = 4'd0;
        dec_hit   = 1'b1;
        dec_blank = 1'b0;
        case ({ssd_s2_q[7:1], 1'b1})
            8'h03: dec_val = 4'd0;
            8'h9F: dec_val = 4'd1;
            8'h25: dec_val = 4'd2;
            8'h0D: dec_val = 4'd3;
            8'h99: dec_val = 4'd4;
            8'h49: dec_val = 4'd5;
            8'h41: dec_val = 4'd6;
            8'h1F: dec_val = 4'd7;
            8'h01: dec_val = 4'd8;
            8'h09: dec_val = 4'd9;
`ifdef SSD_HEX_DECODE_EN
            8'h11: dec_val = 4'hA;
            8'hC1: dec_val = 4'hB;
            8'h63: dec_val = 4'hC;
            8'h85: dec_val = 4'hD;
            8'h61: dec_val = 4'hE;
            8'h71: dec_val = 4'hF;
`endif
            8'hFF: begin
                dec_hit   = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_hit = 1'b0;
        endcase
    end

    // Timeout is applied first so a same-cycle commit overrides it.
    always_comb begin
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        err_d     = err_q;
        dp_d      = dp_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        bus_err_d = do_bus_err;
        for (int k = 0; k < 4; k++) begin
            if (tmo_q[k] != TMO_LIM) tmo_d[k] = tmo_q[k] + 24'd1;
            else                     tmo_d[k] = tmo_q[k];
            if (tmo_d[k] == TMO_LIM) valid_d[k] = 1'b0;
        end
        if (do_commit) begin
            tmo_d[commit_idx] = '0;
            upd_d             = 1'b1;
            upd_idx_d         = commit_idx;
            dp_d[commit_idx]  = ~ssd_s2_q[0];
            if (dec_hit) begin
                bcd_d[{commit_idx, 2'b00} +: 4] = dec_val;
                valid_d[commit_idx] = 1'b1;
                err_d[commit_idx]   = 1'b0;
            end else if (dec_blank) begin
                valid_d[commit_idx] = 1'b0;
                err_d[commit_idx]   = 1'b0;
            end else begin
                valid_d[commit_idx] = 1'b0;
                err_d[commit_idx]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q     <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            dp_q      <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            bus_err_q <= 1'b0;
            for (int k = 0; k < 4; k++) tmo_q[k] <= '0;
        end else begin
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            dp_q      <= dp_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            bus_err_q <= bus_err_d;
            for (int k = 0; k < 4; k++) tmo_q[k] <= tmo_d[k];
        end
    end

    assign bcd_out   = bcd_q;
    assign valid_out = valid_q;
    assign err_out   = err_q;
    assign dp_out    = dp_q;
    assign upd       = upd_q;
    assign upd_idx   = upd_idx_q;
    assign bus_err   = bus_err_q;

endmodule
